alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
- Operand-fetch and write-back stage wrapped around the combinational ALU.
- Holds the 16x16 general register file and accepts one instruction at a time from the decoder via valid/ready.
- Drives the ALU's r1/r2/opcode from registered operands, then captures rout into the destination register and updates the PSR flag register.

Parameters:
- NREGS, 16, number of general registers (address width = clog2(NREGS) = 4)
- DW, 16, datapath width; must match the ALU

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decoder has an instruction
- issue_ready  out  1  stage can accept an instruction (IDLE only)
- issue_op  in  8  ALU opcode
- issue_rdest  in  4  destination register index, also second operand source
- issue_rsrc  in  4  source register index
- issue_imm_en  in  1  1: source operand = issue_imm instead of R[rsrc]
- issue_imm  in  16  immediate operand
- alu_r1  out  16  to ALU r1 (source operand)
- alu_r2  out  16  to ALU r2 (destination register value)
- alu_opcode  out  8  to ALU opcode
- alu_rout  in  16  from ALU rout
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse, with done, for an unsupported opcode
- psr  out  8  flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7; other bits 0
- dbg_raddr  in  4  debug read address
- dbg_rdata  out  16  combinational R[dbg_raddr]

Behaviour:
- Reset values:
  - all registers, alu_r1, alu_r2 = 0
  - alu_opcode = 8'h00
  - psr = 0; done = 0; illegal = 0
  - state = IDLE; issue_ready = 1 in the cycle after reset deasserts
- FSM: IDLE -> EXEC -> WB -> IDLE. issue_ready = (state == IDLE).
- IDLE, on issue_valid:
  - latch alu_r1 = issue_imm_en ? issue_imm : R[rsrc]
  - latch alu_r2 = R[rdest], alu_opcode = issue_op, and rdest
  - go to EXEC
- EXEC: ALU inputs stable for a full cycle so combinational rout settles; go to WB.
- WB, at the clock edge leaving WB:
  - write R[rdest] = alu_rout, unless opcode is CMP (8'h0B) or unsupported
  - update psr; pulse done in this cycle
  - return to IDLE
- Latency and throughput: handshake at cycle 0, done in cycle 2, result readable via dbg in cycle 3. One instruction per 3 cycles; no overlap, so no hazards.
- Supported opcodes: 01, 02, 03, 04, 05, 06, 07, 08, 09, 0B, 0C, 0F, 84.
- Any other opcode: no register write, psr unchanged, illegal=1 with done.
- rsrc == rdest is legal; both operands read the same register.
- alu_opcode and operands hold their values in IDLE after retirement; they are not cleared.
- PSR update (S = alu_r1, D = alu_r2, 17-bit arithmetic; only the listed opcodes touch psr, others leave it unchanged):
  - ADD 05: C = carry out of D+S; F = (D[15]==S[15]) && (sum[15]!=D[15]).
  - SUB 09: C = carry out of S + ~D + 1; F = (S[15]!=D[15]) && (res[15]!=S[15]).
  - CMP 0B: Z = (S==D); L = (D <u S); N = (D <s S); C and F cleared.
  - ADDC 07: psr unchanged; the ALU's own carry governs the result.
- Reset asserted in EXEC or WB: abort to IDLE; no write, no done, psr cleared.
- issue_valid while not ready is ignored; the decoder must hold it.

Optional Feature:
- Macro: ALU_PSR_EN
- Defined: psr computed and updated as above.
- Undefined: psr output tied to 8'h00, flag logic omitted. Register writes, done and illegal are unchanged.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND=8'h01 ... OP_LSH=8'h84)
  - PSR bit indices (PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7)
  - state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2)
  - DW
- One sub-module: reg_file_16x16, with two asynchronous read ports, one debug read port, one synchronous write port, and synchronous reset to zero.

Test Plan:
- Reset, then issue ADD R1,R2 with R1=3, R2=4 (preloaded via immediate ADD to zero regs) -> done at cycle 2, R2=7, psr=0.
- ADD imm 16'h0001 to R3=16'h7FFF -> R3=16'h8000, psr F=1, C=0; ADD imm 1 to 16'hFFFF -> result 0, C=1.
- CMP R4=5 (dest) vs imm 5 -> Z=1, L=0, N=0, R4 unchanged; CMP R4=16'hFFFF vs imm 1 -> L=0, N=1.
- Opcode 8'h0A -> illegal and done pulse together, no register change, psr unchanged.
- Hold issue_valid high continuously -> accepts exactly every 3rd cycle, issue_ready low in EXEC/WB.
- Assert reset during WB of ADD to R5 -> R5 stays 0, no done, state IDLE next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the ALU issue / write-back stage: datapath
//            width, opcode values, PSR bit positions and FSM state encoding.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 16;

  // Opcodes understood by the ALU
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_MOV  = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SHR  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_DEC  = 8'h0C;
  localparam logic [7:0] OP_NEG  = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // PSR flag bit positions
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // True for every opcode the ALU implements
  function automatic logic op_supported(input logic [7:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_MOV, OP_ADDC,
      OP_SHR, OP_SUB, OP_CMP, OP_DEC, OP_NEG, OP_LSH: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_16x16.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_16x16
// Purpose  : General register file. Two asynchronous operand read ports, one
//            asynchronous debug read port, one synchronous write port, and a
//            synchronous clear of every entry on reset.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_16x16 #(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  // Next register contents: a single entry replaced on a write
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Register storage, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign dbg_rdata = regs_q[dbg_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_wb
// Purpose  : Operand fetch and write-back around an external combinational
//            ALU. Accepts one instruction in IDLE, holds the ALU inputs for
//            EXEC, writes the result and retires in WB (3 cycles per insn).
// Config   : ALU_PSR_EN - when defined the PSR flags are computed and kept;
//            when undefined psr reads 8'h00 and the flag logic is absent.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [7:0]               issue_op,
  input  logic [$clog2(NREGS)-1:0] issue_rdest,
  input  logic [$clog2(NREGS)-1:0] issue_rsrc,
  input  logic                     issue_imm_en,
  input  logic [DW-1:0]            issue_imm,
  output logic [DW-1:0]            alu_r1,
  output logic [DW-1:0]            alu_r2,
  output logic [7:0]               alu_opcode,
  input  logic [DW-1:0]            alu_rout,
  output logic                     done,
  output logic                     illegal,
  output logic [7:0]               psr,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [DW-1:0]            dbg_rdata
);

  localparam int AW = $clog2(NREGS);

  state_e        state_q, state_d;
  logic [DW-1:0] alu_r1_q, alu_r1_d;
  logic [DW-1:0] alu_r2_q, alu_r2_d;
  logic [7:0]    alu_opcode_q, alu_opcode_d;
  logic [AW-1:0] rdest_q, rdest_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;

  logic          rf_we;
  logic [DW-1:0] rf_rdata_a;
  logic [DW-1:0] rf_rdata_b;

  reg_file_16x16 #(
    .NREGS (NREGS),
    .DW    (DW),
    .AW    (AW)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .we        (rf_we),
    .waddr     (rdest_q),
    .wdata     (alu_rout),
    .raddr_a   (issue_rsrc),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (issue_rdest),
    .rdata_b   (rf_rdata_b),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  // Sequencing: capture operands in IDLE, let the ALU settle in EXEC,
  // commit in WB. done/illegal are registered so they are high for WB.
  always_comb begin
    state_d      = state_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    alu_opcode_d = alu_opcode_q;
    rdest_d      = rdest_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    rf_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          alu_r1_d     = issue_imm_en ? issue_imm : rf_rdata_a;
          alu_r2_d     = rf_rdata_b;
          alu_opcode_d = issue_op;
          rdest_d      = issue_rdest;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        done_d    = 1'b1;
        illegal_d = !op_supported(alu_opcode_q);
        state_d   = WB;
      end
      WB: begin
        // CMP only produces flags; unsupported opcodes produce nothing
        rf_we   = op_supported(alu_opcode_q) && (alu_opcode_q != OP_CMP);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      alu_opcode_q <= 8'h00;
      rdest_q      <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      alu_opcode_q <= alu_opcode_d;
      rdest_q      <= rdest_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef ALU_PSR_EN
  logic [7:0] psr_q, psr_d;
  logic [DW:0] add_ext;
  logic [DW:0] sub_ext;

  // Flag update from the held operands (S = alu_r1, D = alu_r2) in WB
  always_comb begin
    add_ext = {1'b0, alu_r2_q} + {1'b0, alu_r1_q};
    sub_ext = {1'b0, alu_r1_q} + {1'b0, ~alu_r2_q} + {{DW{1'b0}}, 1'b1};
    psr_d   = psr_q;
    if (state_q == WB) begin
      case (alu_opcode_q)
        OP_ADD: begin
          psr_d[PSR_C] = add_ext[DW];
          psr_d[PSR_F] = (alu_r2_q[DW-1] == alu_r1_q[DW-1]) &&
                         (add_ext[DW-1] != alu_r2_q[DW-1]);
        end
        OP_SUB: begin
          psr_d[PSR_C] = sub_ext[DW];
          psr_d[PSR_F] = (alu_r1_q[DW-1] != alu_r2_q[DW-1]) &&
                         (sub_ext[DW-1] != alu_r1_q[DW-1]);
        end
        OP_CMP: begin
          psr_d[PSR_Z] = (alu_r1_q == alu_r2_q);
          psr_d[PSR_L] = (alu_r2_q < alu_r1_q);
          psr_d[PSR_N] = ($signed(alu_r2_q) < $signed(alu_r1_q));
          psr_d[PSR_C] = 1'b0;
          psr_d[PSR_F] = 1'b0;
        end
        default: psr_d = psr_q;
      endcase
    end
  end

  // Flag register; an abort by reset clears it like everything else
  always_ff @(posedge clk) begin
    if (reset) psr_q <= 8'h00;
    else       psr_q <= psr_d;
  end

  assign psr = psr_q;
`else
  assign psr = 8'h00;
`endif

  assign issue_ready = (state_q == IDLE);
  assign alu_r1      = alu_r1_q;
  assign alu_r2      = alu_r2_q;
  assign alu_opcode  = alu_opcode_q;
  // A retirement interrupted by reset must not be reported
  assign done        = done_q & ~reset;
  assign illegal     = illegal_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_wb
// Purpose  : Self-checking bench for alu_issue_wb with a behavioural ALU and
//            a reference model of the register file and flags.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_wb;

`ifdef ALU_PSR_EN
  localparam bit PSR_ON = 1'b1;
`else
  localparam bit PSR_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_op;
  logic [3:0]  issue_rdest;
  logic [3:0]  issue_rsrc;
  logic        issue_imm_en;
  logic [15:0] issue_imm;
  logic [15:0] alu_r1;
  logic [15:0] alu_r2;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_rout;
  logic        done;
  logic        illegal;
  logic [7:0]  psr;
  logic [3:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  int total = 0;
  int bad   = 0;

  alu_issue_wb dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rdest  (issue_rdest),
    .issue_rsrc   (issue_rsrc),
    .issue_imm_en (issue_imm_en),
    .issue_imm    (issue_imm),
    .alu_r1       (alu_r1),
    .alu_r2       (alu_r2),
    .alu_opcode   (alu_opcode),
    .alu_rout     (alu_rout),
    .done         (done),
    .illegal      (illegal),
    .psr          (psr),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU attached to the stage (s = r1 source, d = r2 destination)
  function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [15:0] s, input logic [15:0] d);
    case (op)
      8'h01:   return d & s;
      8'h02:   return d | s;
      8'h03:   return d ^ s;
      8'h04:   return ~s;
      8'h05:   return d + s;
      8'h06:   return s;
      8'h07:   return d + s + 16'd1;
      8'h08:   return d >> 1;
      8'h09:   return s - d;
      8'h0B:   return s - d;
      8'h0C:   return d - 16'd1;
      8'h0F:   return 16'd0 - d;
      8'h84:   return d << s[3:0];
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb alu_rout = alu_fn(alu_opcode, alu_r1, alu_r2);

  // ---------------- reference model ----------------
  logic [15:0] mregs [16];
  logic [7:0]  mpsr;

  function automatic bit legal_op(input logic [7:0] op);
    return op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                      8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84};
  endfunction

  function automatic int sx(input logic [15:0] v);
    if (v[15]) return int'(v) - 65536;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
    mpsr = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic ie, input logic [15:0] imm,
                            output logic [15:0] s, output logic [15:0] d,
                            output logic [15:0] val, output logic [7:0] p, output logic ill);
    int us, ud, ss, sd;
    s   = ie ? imm : mregs[rs];
    d   = mregs[rd];
    ill = !legal_op(op);
    us  = int'(s);
    ud  = int'(d);
    ss  = sx(s);
    sd  = sx(d);
    if (!ill && op != 8'h0B) mregs[rd] = alu_fn(op, s, d);
    if (PSR_ON) begin
      if (op == 8'h05) begin
        mpsr[0] = (us + ud) > 65535;
        mpsr[5] = (sd + ss > 32767) || (sd + ss < -32768);
      end else if (op == 8'h09) begin
        mpsr[0] = (us >= ud);
        mpsr[5] = (ss - sd > 32767) || (ss - sd < -32768);
      end else if (op == 8'h0B) begin
        mpsr[6] = (s == d);
        mpsr[2] = (ud < us);
        mpsr[7] = (sd < ss);
        mpsr[0] = 1'b0;
        mpsr[5] = 1'b0;
      end
    end
    val = mregs[rd];
    p   = mpsr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one instruction starting just after a rising edge in IDLE and
  // follow it through EXEC, WB and the first IDLE cycle afterwards.
  task automatic run_insn(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic ie, input logic [15:0] imm,
                          input logic [15:0] es, input logic [15:0] ed,
                          input logic [15:0] eval, input logic [7:0] epsr, input logic eill);
    issue_op     = op;
    issue_rdest  = rd;
    issue_rsrc   = rs;
    issue_imm_en = ie;
    issue_imm    = imm;
    issue_valid  = 1'b1;
    dbg_raddr    = rd;
    @(negedge clk);
    chk("ready_idle", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;
    issue_valid  = 1'b0;
    issue_op     = 8'($urandom);
    issue_imm    = 16'($urandom);
    issue_rsrc   = 4'($urandom);
    issue_rdest  = 4'($urandom);
    @(negedge clk);
    chk("ready_exec", 32'(issue_ready), 32'd0);
    chk("done_exec", 32'(done), 32'd0);
    chk("alu_r1", 32'(alu_r1), 32'(es));
    chk("alu_r2", 32'(alu_r2), 32'(ed));
    chk("alu_opcode", 32'(alu_opcode), 32'(op));
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_wb", 32'(done), 32'd1);
    chk("illegal_wb", 32'(illegal), 32'(eill));
    @(posedge clk); #1;
    @(negedge clk);
    chk("result", 32'(dbg_rdata), 32'(eval));
    chk("psr", 32'(psr), 32'(epsr));
    chk("done_after", 32'(done), 32'd0);
    chk("opcode_hold", 32'(alu_opcode), 32'(op));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        ie;
    logic [15:0] imm;
    logic [15:0] val;
    logic [7:0]  psr;
    logic        ill;
  } vec_t;

  function automatic logic [7:0] fp(input logic [7:0] v);
    return PSR_ON ? v : 8'h00;
  endfunction

  initial begin
    vec_t        tbl [14];
    logic [7:0]  ops [15];
    logic [15:0] s, d, v;
    logic [7:0]  p;
    logic        il;

    tbl[0]  = '{8'h05, 4'd1, 4'd0, 1'b1, 16'h0003, 16'h0003, fp(8'h00), 1'b0};
    tbl[1]  = '{8'h05, 4'd2, 4'd0, 1'b1, 16'h0004, 16'h0004, fp(8'h00), 1'b0};
    tbl[2]  = '{8'h05, 4'd2, 4'd1, 1'b0, 16'h0000, 16'h0007, fp(8'h00), 1'b0};
    tbl[3]  = '{8'h05, 4'd3, 4'd0, 1'b1, 16'h7FFF, 16'h7FFF, fp(8'h00), 1'b0};
    tbl[4]  = '{8'h05, 4'd3, 4'd0, 1'b1, 16'h0001, 16'h8000, fp(8'h20), 1'b0};
    tbl[5]  = '{8'h05, 4'd6, 4'd0, 1'b1, 16'hFFFF, 16'hFFFF, fp(8'h00), 1'b0};
    tbl[6]  = '{8'h05, 4'd6, 4'd0, 1'b1, 16'h0001, 16'h0000, fp(8'h01), 1'b0};
    tbl[7]  = '{8'h05, 4'd4, 4'd0, 1'b1, 16'h0005, 16'h0005, fp(8'h00), 1'b0};
    tbl[8]  = '{8'h0B, 4'd4, 4'd0, 1'b1, 16'h0005, 16'h0005, fp(8'h40), 1'b0};
    tbl[9]  = '{8'h05, 4'd4, 4'd0, 1'b1, 16'hFFFA, 16'hFFFF, fp(8'h40), 1'b0};
    tbl[10] = '{8'h0B, 4'd4, 4'd0, 1'b1, 16'h0001, 16'hFFFF, fp(8'h80), 1'b0};
    tbl[11] = '{8'h0A, 4'd4, 4'd0, 1'b1, 16'h1234, 16'hFFFF, fp(8'h80), 1'b1};
    tbl[12] = '{8'h09, 4'd2, 4'd0, 1'b1, 16'h0003, 16'hFFFC, fp(8'h80), 1'b0};
    tbl[13] = '{8'h01, 4'd2, 4'd2, 1'b0, 16'h0000, 16'hFFFC, fp(8'h80), 1'b0};

    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84, 8'h0A, 8'hFF};

    reset = 1'b1; issue_valid = 1'b0; issue_op = 8'h00; issue_rdest = 4'd0;
    issue_rsrc = 4'd0; issue_imm_en = 1'b0; issue_imm = 16'h0000; dbg_raddr = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_psr", 32'(psr), 32'd0);
    chk("rst_r1", 32'(alu_r1), 32'd0);
    chk("rst_r2", 32'(alu_r2), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      dbg_raddr = 4'(i);
      @(negedge clk);
      chk("rst_reg", 32'(dbg_rdata), 32'd0);
      @(posedge clk); #1;
    end

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie, tbl[i].imm, s, d, v, p, il);
      run_insn(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie, tbl[i].imm,
               s, d, tbl[i].val, tbl[i].psr, tbl[i].ill);
    end

    // Random instructions against the model
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  rop;
      logic [3:0]  rrd, rrs;
      logic        rie;
      logic [15:0] rimm;
      rop  = ops[$urandom_range(0, 14)];
      rrd  = 4'($urandom);
      rrs  = 4'($urandom);
      rie  = 1'($urandom);
      rimm = 16'($urandom);
      model_step(rop, rrd, rrs, rie, rimm, s, d, v, p, il);
      run_insn(rop, rrd, rrs, rie, rimm, s, d, v, p, il);
    end

    // Back-to-back: valid held high, accepted every third cycle
    for (int k = 0; k < 3; k++) model_step(8'h05, 4'd8, 4'd0, 1'b1, 16'h0001, s, d, v, p, il);
    issue_op = 8'h05; issue_rdest = 4'd8; issue_rsrc = 4'd0;
    issue_imm_en = 1'b1; issue_imm = 16'h0001; dbg_raddr = 4'd8;
    issue_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(issue_ready), 32'((k % 3) == 0));
      chk("b2b_done", 32'(done), 32'((k % 3) == 2));
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    @(negedge clk);
    chk("b2b_result", 32'(dbg_rdata), 32'(v));
    chk("b2b_psr", 32'(psr), 32'(p));
    @(posedge clk); #1;

    // Reset during WB aborts the write and the done pulse
    issue_op = 8'h05; issue_rdest = 4'd5; issue_imm_en = 1'b1; issue_imm = 16'h0009;
    dbg_raddr = 4'd5;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_ready", 32'(issue_ready), 32'd1);
    chk("abort_r5", 32'(dbg_rdata), 32'd0);
    chk("abort_psr", 32'(psr), 32'd0);
    @(posedge clk); #1;

    // Normal operation resumes after the abort
    model_step(8'h05, 4'd1, 4'd0, 1'b1, 16'h0055, s, d, v, p, il);
    run_insn(8'h05, 4'd1, 4'd0, 1'b1, 16'h0055, s, d, v, p, il);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
